frame_streamer: RTL and testbench

- Transmit end of the raster pixel stream protocol (`pixel_in`/`pixel_in_valid`) consumed by `pixel_loader` at the head of the Canny pipeline.
- Holds one grayscale frame in internal RAM, loaded through a simple host write port.
- On a start pulse, replays the frame in raster order (row 0 col 0 first) with a per-pixel valid, plus optional inter-row blanking.
- Replaces file-driven stimulus so the pipeline can be exercised in-system.

---
 rtl/canny_pkg.sv | 22 ++
 rtl/frame_ram.sv | 40 ++++
 rtl/frame_streamer.sv | 153 +++++++++++++++
 tb/tb_frame_streamer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/canny_pkg.sv
// Shared types and defaults for the Canny front end: image geometry,
// the frame streamer state encoding and the grayscale pixel type.
package canny_pkg;

    localparam int IMG_W_DEF = 512;
    localparam int IMG_H_DEF = 512;

    typedef logic [7:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        GAP,
        FLUSH
    } stream_state_t;

    // Counter width that never collapses to zero bits for degenerate ranges.
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/frame_ram.sv
// Single-clock simple dual-port frame store: one write port, one read port
// whose output register only updates on a read, so it holds between reads.
module frame_ram
    import canny_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = clog2_min1(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Contents are deliberately never reset so a frame survives a stream abort.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/frame_streamer.sv
// Replays a host-loaded grayscale frame in raster order with a per-pixel
// valid and optional blanking between rows, feeding pixel_loader.
module frame_streamer
    import canny_pkg::*;
#(
    parameter int IMG_W     = IMG_W_DEF,
    parameter int IMG_H     = IMG_H_DEF,
    parameter int ITEM_SIZE = 8,
    parameter int ROW_GAP   = 0,
    localparam int ADDR_W   = clog2_min1(IMG_W * IMG_H)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [ITEM_SIZE-1:0] wr_data,
    output logic                 wr_reject,
    input  logic                 start,
    output logic [ITEM_SIZE-1:0] pixel_out,
    output logic                 pixel_out_valid,
    output logic                 busy,
    output logic                 done
);

    localparam int DEPTH = IMG_W * IMG_H;
    localparam int COL_W = clog2_min1(IMG_W);
    localparam int ROW_W = clog2_min1(IMG_H);
    localparam int GAP_W = clog2_min1(ROW_GAP + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((ROW_GAP > 0) ? ROW_GAP - 1 : 0);

    stream_state_t     state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              wr_reject_q, wr_reject_d;

    logic rd_en;
    logic idle;
    logic in_range;
    logic ram_wr_en;

    assign idle = (state_q == IDLE);
    // Widened compare: for power-of-two frames DEPTH does not fit in ADDR_W.
    assign in_range  = ({1'b0, wr_addr} < (ADDR_W + 1)'(DEPTH));
    assign ram_wr_en = wr_en && idle && in_range && !rst;

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        col_d       = col_q;
        row_d       = row_q;
        gap_d       = gap_q;
        rd_en       = 1'b0;
        done_d      = 1'b0;
        wr_reject_d = wr_en && !idle && in_range;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = STREAM;
                    rd_addr_d = '0;
                    col_d     = '0;
                    row_d     = '0;
                    gap_d     = '0;
                end
            end
            STREAM: begin
                rd_en     = 1'b1;
                rd_addr_d = rd_addr_q + ADDR_W'(1);
                col_d     = col_q + COL_W'(1);
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        state_d = FLUSH;
                    end else if (ROW_GAP > 0) begin
                        state_d = GAP;
                        gap_d   = '0;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = STREAM;
                    row_d   = row_q + ROW_W'(1);
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            FLUSH: begin
                // Last read is landing in the output register this cycle.
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        valid_d = rd_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            col_q       <= '0;
            row_q       <= '0;
            gap_q       <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            wr_reject_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            col_q       <= col_d;
            row_q       <= row_d;
            gap_q       <= gap_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            wr_reject_q <= wr_reject_d;
        end
    end

    // The RAM read register doubles as the pixel output register.
    frame_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (ITEM_SIZE),
        .ADDR_W (ADDR_W)
    ) u_frame_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ram_wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr_q),
        .rd_data (pixel_out)
    );

    assign pixel_out_valid = valid_q;
    assign busy            = !idle;
    assign done            = done_q;
    assign wr_reject       = wr_reject_q;

endmodule

// File: tb/tb_frame_streamer.sv
// Scoreboard bench: two 4x3 streamers (ROW_GAP 0 and 2) share stimulus; a
// frame-level model predicts pixel/done/reject timing, monitors compare.
module tb_frame_streamer;

    localparam int W     = 4;
    localparam int H     = 3;
    localparam int DEPTH = W * H;

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       mon_en;

    int total;
    int bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check(string name, int inst, int c, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d edge=%0d got=%0h exp=%0h", name, inst, c, got, exp);
        end
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int G = gi * 2;

        logic [7:0] pixel_out;
        logic       pixel_out_valid;
        logic       busy;
        logic       done;
        logic       wr_reject;

        frame_streamer #(
            .IMG_W     (W),
            .IMG_H     (H),
            .ITEM_SIZE (8),
            .ROW_GAP   (G)
        ) dut (
            .clk             (clk),
            .rst             (rst),
            .wr_en           (wr_en),
            .wr_addr         (wr_addr),
            .wr_data         (wr_data),
            .wr_reject       (wr_reject),
            .start           (start),
            .pixel_out       (pixel_out),
            .pixel_out_valid (pixel_out_valid),
            .busy            (busy),
            .done            (done)
        );

        // Reference model state: the frame as the host sees it, plus the
        // window of edges during which this instance is busy.
        logic [7:0] mem_m [DEPTH];
        int         ecnt = 0;
        int         idle_from = 0;
        int         busy_start = 0;
        logic [7:0] exp_last = 8'h00;
        exp_t       pq[$];
        int         dq[$];
        int         rq[$];

        always @(posedge clk) begin : model
            int  e;
            bit  was_idle;
            ecnt++;
            e = ecnt;
            if (rst) begin
                idle_from  = e;
                busy_start = e;
                exp_last   = 8'h00;
                pq.delete();
                dq.delete();
            end else begin
                was_idle = (e > idle_from);
                if (wr_en && int'(wr_addr) < DEPTH) begin
                    if (was_idle) mem_m[wr_addr] = wr_data;
                    else rq.push_back(e);
                end
                if (start && was_idle) begin
                    busy_start = e;
                    for (int i = 0; i < DEPTH; i++) begin
                        pq.push_back('{d: mem_m[i], c: e + 1 + i + (i / W) * G});
                    end
                    idle_from = e + 1 + DEPTH + (H - 1) * G;
                    dq.push_back(idle_from);
                end
            end
        end

        always @(negedge clk) begin : monitor
            int c;
            bit exp_v;
            bit exp_d;
            bit exp_r;
            if (mon_en) begin
                c = ecnt;
                check("busy", gi, c, 32'(busy), 32'((c >= busy_start) && (c < idle_from)));

                exp_v = (pq.size() > 0) && (pq[0].c == c);
                check("valid", gi, c, 32'(pixel_out_valid), 32'(exp_v));
                if (exp_v) begin
                    exp_last = pq[0].d;
                    void'(pq.pop_front());
                end
                check("pixel", gi, c, 32'(pixel_out), 32'(exp_last));

                exp_d = (dq.size() > 0) && (dq[0] == c);
                if (exp_d) void'(dq.pop_front());
                check("done", gi, c, 32'(done), 32'(exp_d));

                exp_r = (rq.size() > 0) && (rq[0] == c);
                if (exp_r) void'(rq.pop_front());
                check("wr_reject", gi, c, 32'(wr_reject), 32'(exp_r));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        mon_en  = 1'b0;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        tick(2);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Load ramp frame 10..21 and stream it.
        for (int i = 0; i < DEPTH; i++) begin
            wr_en   = 1'b1;
            wr_addr = 4'(i);
            wr_data = 8'(i + 10);
            tick(1);
        end
        wr_en = 1'b0;
        tick(2);
        pulse_start();
        tick(25);

        // Write and start on the same edge: new pixel 0 must be streamed.
        wr_en   = 1'b1;
        wr_addr = 4'd0;
        wr_data = 8'h55;
        start   = 1'b1;
        tick(1);
        wr_en = 1'b0;
        start = 1'b0;
        tick(25);

        // Mid-stream write is rejected, mid-stream start is ignored.
        pulse_start();
        tick(3);
        wr_en   = 1'b1;
        wr_addr = 4'd5;
        wr_data = 8'hFF;
        tick(1);
        wr_en = 1'b0;
        tick(2);
        pulse_start();
        tick(25);

        // Reset mid-frame, then replay from the start.
        pulse_start();
        tick(6);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(3);
        pulse_start();
        tick(25);

        // Randomised mix of writes (including out-of-range), starts and resets.
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    wr_en   = 1'b1;
                    wr_addr = 4'($urandom_range(0, 15));
                    wr_data = 8'($urandom);
                    tick(1);
                    wr_en = 1'b0;
                end
                1: begin
                    start = 1'b1;
                    if ($urandom_range(0, 1) == 1) begin
                        wr_en   = 1'b1;
                        wr_addr = 4'($urandom_range(0, 15));
                        wr_data = 8'($urandom);
                    end
                    tick(1);
                    start = 1'b0;
                    wr_en = 1'b0;
                end
                2: tick($urandom_range(1, 20));
                default: begin
                    if ($urandom_range(0, 7) == 0) rst = 1'b1;
                    tick(1);
                    rst = 1'b0;
                end
            endcase
        end
        tick(40);

        check("drain_pixels", 0, g_inst[0].ecnt, 32'(g_inst[0].pq.size()), 32'd0);
        check("drain_pixels", 1, g_inst[1].ecnt, 32'(g_inst[1].pq.size()), 32'd0);
        check("drain_done", 0, g_inst[0].ecnt, 32'(g_inst[0].dq.size()), 32'd0);
        check("drain_done", 1, g_inst[1].ecnt, 32'(g_inst[1].dq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
